// File: rtl/blink_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// blink_pkg -- shared types and constants for the blink sequencer.
//   blink_state_t      : sequencer FSM states (IDLE, ON, OFF, GAP)
//   COUNT_W            : width of blink_count / blinks_left
//   GAP_TICKS_DEFAULT  : default number of half-periods between repeats
// ---------------------------------------------------------------------------
package blink_pkg;

  localparam int COUNT_W           = 4;
  localparam int GAP_TICKS_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } blink_state_t;

endpackage

// File: rtl/blink_sequencer_if.sv
// ---------------------------------------------------------------------------
// blink_sequencer_if -- control/status bundle of the blink sequencer.
//   start_i        : request to begin a sequence (level, sampled every cycle)
//   blink_count_i  : blinks per sequence, latched when start is accepted
//   repeat_i       : loop after a gap, sampled at the end of the final OFF
//   abort_i        : cancel a running sequence (only with BLINK_ABORT_EN)
//   led_out_o      : registered LED drive
//   busy_o         : high in every state except IDLE
//   done_o         : one-cycle pulse on normal completion
//   blinks_left_o  : remaining blinks including the current one
//   state_o        : FSM state, for debug and checkers
// Modports: master drives requests, slave is the sequencer.
//
// Handshake: start_i acts as "valid" and !busy_o acts as "ready". A request
// is accepted on a rising edge where start_i=1 and busy_o=0; while busy_o=1
// start_i is ignored and nothing latched changes. done_o is a single-cycle
// completion strobe, never held.
// ---------------------------------------------------------------------------
interface blink_sequencer_if;
  import blink_pkg::*;

  logic                start_i;
  logic [COUNT_W-1:0]  blink_count_i;
  logic                repeat_i;
`ifdef BLINK_ABORT_EN
  logic                abort_i;
`endif
  logic                led_out_o;
  logic                busy_o;
  logic                done_o;
  logic [COUNT_W-1:0]  blinks_left_o;
  blink_state_t        state_o;

  modport master (
`ifdef BLINK_ABORT_EN
    output abort_i,
`endif
    output start_i, blink_count_i, repeat_i,
    input  led_out_o, busy_o, done_o, blinks_left_o, state_o
  );

  modport slave (
`ifdef BLINK_ABORT_EN
    input  abort_i,
`endif
    input  start_i, blink_count_i, repeat_i,
    output led_out_o, busy_o, done_o, blinks_left_o, state_o
  );

endinterface

// File: rtl/blink_sequencer_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen -- half-period prescaler for the blink sequencer.
// Counts 0..DIVISOR-1 while enabled and flags tick_o for the single cycle in
// which the count sits at DIVISOR-1, then wraps to 0.
//   Clock    : rising-edge clock
//   Resetn   : asynchronous active-low reset
//   clear_i  : force the count to 0 (wins over enable_i)
//   enable_i : advance the count
//   tick_o   : one-cycle strobe at the last count of each half-period
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int DIVISOR = 25000000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  // Width is sized from DIVISOR itself so large dividers never overflow.
  localparam int            CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/blink_sequencer.sv
// ---------------------------------------------------------------------------
// blink_sequencer -- blinks an LED blink_count times (ON then OFF, each phase
// DIVISOR cycles), optionally looping with a GAP_TICKS half-period dark gap.
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset
//   bus    : blink_sequencer_if.slave (start/count/repeat in, LED/status out)
// Parameters: DIVISOR (cycles per half-period), GAP_TICKS (gap half-periods).
// Optional feature: define BLINK_ABORT_EN to add the abort_i input, which
// returns any running sequence to IDLE at the next edge without done.
// ---------------------------------------------------------------------------
module blink_sequencer
  import blink_pkg::*;
#(
  parameter int DIVISOR   = 25000000,
  parameter int GAP_TICKS = GAP_TICKS_DEFAULT
) (
  input  logic              Clock,
  input  logic              Resetn,
  blink_sequencer_if.slave  bus
);

  localparam int            GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

  blink_state_t        state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [COUNT_W-1:0]  left_q,  left_d;
  logic [GW-1:0]       gap_q,   gap_d;
  logic                led_q,   led_d;
  logic                done_q,  done_d;
  logic                tick;
  logic                presc_clear;

  tick_gen #(.DIVISOR(DIVISOR)) u_tick_gen (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .clear_i  (presc_clear),
    .enable_i (state_q != ST_IDLE),
    .tick_o   (tick)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    left_d      = left_q;
    gap_d       = gap_q;
    done_d      = 1'b0;
    presc_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Holding the prescaler at 0 here makes the first ON phase exact.
        presc_clear = 1'b1;
        if (bus.start_i) begin
          if (bus.blink_count_i != '0) begin
            count_d = bus.blink_count_i;
            left_d  = bus.blink_count_i;
            state_d = ST_ON;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ST_ON: begin
        if (tick) state_d = ST_OFF;
      end
      ST_OFF: begin
        if (tick) begin
          if (left_q > COUNT_W'(1)) begin
            left_d  = left_q - COUNT_W'(1);
            state_d = ST_ON;
          end else if (bus.repeat_i) begin
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            left_d  = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            left_d  = count_q;
            state_d = ST_ON;
          end else begin
            gap_d   = gap_q + GW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef BLINK_ABORT_EN
    // Abort overrides anything the tick would have done this cycle.
    if (bus.abort_i && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      left_d      = '0;
      gap_d       = '0;
      done_d      = 1'b0;
      presc_clear = 1'b1;
    end
`endif

    led_d = (state_d == ST_ON);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      left_q  <= '0;
      gap_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      left_q  <= left_d;
      gap_q   <= gap_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign bus.led_out_o     = led_q;
  assign bus.busy_o        = (state_q != ST_IDLE);
  assign bus.done_o        = done_q;
  assign bus.blinks_left_o = left_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// ---------------------------------------------------------------------------
// tb_blink_sequencer -- self-checking bench for blink_sequencer with
// DIVISOR=4, GAP_TICKS=2. Expected per-cycle outputs are built from the
// sequence schedule (N blinks of DIVISOR high + DIVISOR low, gap, done) into
// exp_q and compared each cycle on the falling edge.
// Packed expectation layout: {led, busy, done, blinks_left[3:0]}.
// ---------------------------------------------------------------------------
module tb_blink_sequencer;
  import blink_pkg::*;

  localparam int DIV = 4;
  localparam int GAP = 2;

  // ---------------- clock / reset ----------------
  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clock = ~Clock;

  blink_sequencer_if bus ();

  blink_sequencer #(.DIVISOR(DIV), .GAP_TICKS(GAP)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [6:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [6:0] pk(input bit led, input bit busy,
                                    input bit done, input int left);
    return {led, busy, done, 4'(left)};
  endfunction

  // One pass of n blinks; either ends in a gap (more=1) or a done cycle.
  task automatic push_pass(input int n, input bit more);
    for (int b = n; b >= 1; b--) begin
      for (int i = 0; i < DIV; i++) exp_q.push_back(pk(1, 1, 0, b));
      for (int i = 0; i < DIV; i++) exp_q.push_back(pk(0, 1, 0, b));
    end
    if (more) begin
      for (int i = 0; i < GAP * DIV; i++) exp_q.push_back(pk(0, 1, 0, 1));
    end else begin
      exp_q.push_back(pk(0, 0, 1, 0));
    end
  endtask

  task automatic push_idle(input int k);
    for (int i = 0; i < k; i++) exp_q.push_back(pk(0, 0, 0, 0));
  endtask

  // ---------------- driver / checker ----------------
  task automatic cycle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [6:0] expv);
    logic [6:0] obs;
    obs = {bus.led_out_o, bus.busy_o, bus.done_o, bus.blinks_left_o};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed={led,busy,done,left}=%b expected=%b",
             tag, $time, obs, expv);
    end
  endtask

  // Step through every queued expectation; optionally throw stray starts
  // (random counts) at cycles where the sequencer is busy.
  task automatic drain(input string tag, input bit junk);
    logic [6:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cycle();
      bus.start_i = 1'b0;
      check(tag, e);
      if (junk && e[5] && ($urandom_range(0, 7) == 0)) begin
        bus.start_i       = 1'b1;
        bus.blink_count_i = 4'($urandom_range(0, 15));
      end
    end
    bus.start_i = 1'b0;
  endtask

  task automatic run_sequence(input string tag, input int n,
                              input int passes, input bit junk);
    bus.start_i       = 1'b1;
    bus.blink_count_i = 4'(n);
    for (int p = 0; p < passes; p++) begin
      bus.repeat_i = (p < passes - 1);
      push_pass(n, p < passes - 1);
      drain(tag, junk);
    end
    bus.repeat_i = 1'b0;
    push_idle(1);
    drain({tag, "_post"}, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random steps ----------------
  initial begin
    int n;
    int passes;
    bus.start_i       = 1'b0;
    bus.blink_count_i = '0;
    bus.repeat_i      = 1'b0;
`ifdef BLINK_ABORT_EN
    bus.abort_i       = 1'b0;
`endif

    // Reset state.
    #3;
    check("reset", pk(0, 0, 0, 0));
    vectors++;
    assert (bus.state_o === ST_IDLE) else begin
      miscompares++;
      $error("FAIL reset_state observed=%0d expected=%0d", bus.state_o, ST_IDLE);
    end
    cycle();
    cycle();
    Resetn = 1'b1;
    push_idle(2);
    drain("idle", 1'b0);

    // Three blinks, no repeat: done 24 cycles after the first rise.
    run_sequence("cnt3", 3, 1, 1'b0);

    // Zero count: done next cycle, nothing else moves.
    bus.start_i       = 1'b1;
    bus.blink_count_i = 4'd0;
    exp_q.push_back(pk(0, 0, 1, 0));
    push_idle(2);
    drain("cnt0", 1'b0);

    // Repeat once then drop repeat.
    run_sequence("rep2", 2, 2, 1'b0);

    // Start with count 5 while blinks_left=2 must be ignored.
    bus.start_i       = 1'b1;
    bus.blink_count_i = 4'd3;
    push_pass(3, 1'b0);
    for (int i = 0; i < 2 * DIV + 1; i++) begin
      cycle();
      bus.start_i = 1'b0;
      check("busy_start", exp_q.pop_front());
    end
    bus.start_i       = 1'b1;
    bus.blink_count_i = 4'd5;
    drain("busy_start", 1'b0);
    push_idle(1);
    drain("busy_start_post", 1'b0);

    // Reset mid-ON: outputs clear at once, no done afterwards.
    bus.start_i       = 1'b1;
    bus.blink_count_i = 4'd3;
    cycle();
    bus.start_i = 1'b0;
    check("rst_on0", pk(1, 1, 0, 3));
    cycle();
    check("rst_on1", pk(1, 1, 0, 3));
    #1 Resetn = 1'b0;
    #1 check("rst_async", pk(0, 0, 0, 0));
    cycle();
    check("rst_hold", pk(0, 0, 0, 0));
    Resetn = 1'b1;
    push_idle(3);
    drain("rst_nodone", 1'b0);
    run_sequence("after_rst", 1, 1, 1'b0);

`ifdef BLINK_ABORT_EN
    // Abort during OFF with blinks_left=2.
    bus.start_i       = 1'b1;
    bus.blink_count_i = 4'd3;
    for (int i = 0; i < DIV; i++) exp_q.push_back(pk(1, 1, 0, 3));
    for (int i = 0; i < DIV; i++) exp_q.push_back(pk(0, 1, 0, 3));
    for (int i = 0; i < DIV; i++) exp_q.push_back(pk(1, 1, 0, 2));
    exp_q.push_back(pk(0, 1, 0, 2));
    drain("abort_pre", 1'b0);
    bus.abort_i = 1'b1;
    cycle();
    bus.abort_i = 1'b0;
    check("abort", pk(0, 0, 0, 0));
    push_idle(3);
    drain("abort_nodone", 1'b0);
    run_sequence("after_abort", 1, 1, 1'b0);
`endif

    // Randomized sequences with stray starts while busy.
    for (int k = 0; k < 14; k++) begin
      n      = $urandom_range(0, 15);
      passes = (n != 0) ? $urandom_range(1, 2) : 1;
      run_sequence("rand", n, passes, 1'b1);
      push_idle($urandom_range(0, 3));
      drain("rand_idle", 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
